mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 64: width of address, write-data and read-data buses.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive locked grants to one requester while the other requests.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 reqN  input  1  (N=0,1) access request from requester N.
REQ-006 rwN  input  1  1 = read, 0 = write (same polarity as core rw).
REQ-007 lockN  input  1  requester N asks to keep the bus for its next access.
REQ-008 addrN  input  DATA_W  access address.
REQ-009 wdataN  input  DATA_W  write data.
REQ-010 gntN  output  1  access of requester N is accepted this cycle.
REQ-011 rvalidN  output  1  read data for requester N is valid this cycle.
REQ-012 rdataN  output  DATA_W  read data to requester N.
REQ-013 mem_en  output  1  memory access strobe.
REQ-014 mem_rw  output  1  1 = read, 0 = write.
REQ-015 mem_addr, mem_wdata  output  DATA_W  granted requester's address and write data.
REQ-016 mem_rdata  input  DATA_W  memory read data, valid exactly 1 cycle after a read strobe.

Function
REQ-017 The arbiter SHALL grant one access per cycle; transfer occurs on a rising edge with reqN & gntN = 1.
REQ-018 gnt0/gnt1 SHALL be combinational from reqN and registered state, mutually exclusive, and never asserted without the matching reqN.
REQ-019 mem_en SHALL equal gnt0 | gnt1; mem_rw, mem_addr and mem_wdata SHALL mux from the granted requester, and SHALL be 1, 0 and 0 when idle.
REQ-020 State machine: IDLE, OWN0, OWN1, registered; the state names the last granted owner.
REQ-021 Only one requester active: it SHALL be granted regardless of state.
REQ-022 Both requesting, no valid lock: the grant SHALL go to the requester that is not the current owner; from IDLE, requester 0 wins.
REQ-023 Lock: if the owner had lockN = 1 on its last granted cycle and requests again, the owner SHALL keep the grant while hold_cnt < MAX_HOLD-1.
REQ-024 hold_cnt SHALL count consecutive grants to the same owner. It increments on each repeat grant, saturates at MAX_HOLD-1, and clears to 0 on an owner change or any non-granted cycle.
REQ-025 When hold_cnt = MAX_HOLD-1 and the other requester is requesting, the grant SHALL pass to the other requester even if lock is asserted.
REQ-026 A cycle with no grant SHALL move the state to IDLE.
REQ-027 Every granted read SHALL assert rvalidN for exactly one cycle, 1 cycle after the grant, with rdataN = mem_rdata.
REQ-028 rdataN SHALL be 0 when rvalidN is 0; writes produce no rvalid.
REQ-029 Back-to-back reads by alternating requesters SHALL route each rvalid to the correct owner via a registered read-tag.
REQ-030 A read tag pending when a new grant occurs SHALL still complete; the pipeline is one deep, no stall.

Reset
REQ-031 reset = 0 SHALL immediately force: state IDLE, hold_cnt 0, read tag cleared, rvalid0/1 = 0, rdata0/1 = 0.
REQ-032 While reset = 0, gnt0/1 and mem_en SHALL be 0 and mem_rw SHALL be 1.
REQ-033 Reset asserted mid-read SHALL drop the pending rvalid (no rvalid after deassertion).
REQ-034 After reset deassertion, the first rising edge SHALL arbitrate from IDLE.

Verification
REQ-035 req0 = 1, rw0 = 1, addr0 = 0x10; req1 = 0 -> gnt0 = 1, mem_addr = 0x10, mem_rw = 1; next cycle rvalid0 = 1 and rdata0 = mem_rdata.
REQ-036 req0 and req1 both held high, no lock, for 4 cycles -> grants in order 0, 1, 0, 1.
REQ-037 Both requesting, lock0 = 1 continuously, MAX_HOLD = 8 -> 8 consecutive gnt0, then gnt1 in cycle 9.
REQ-038 req1 alone with lock1 = 1 for 20 cycles -> gnt1 every cycle, hold_cnt saturates at 7, no gaps.
REQ-039 Alternating reads 0, 1, 0 with mem_rdata = 0xA, 0xB, 0xC -> rdata0 = 0xA, rdata1 = 0xB, rdata0 = 0xC, each in the cycle after its grant.
REQ-040 reset pulled low one cycle after a read grant to requester 1 -> rvalid1 never rises, outputs are at reset values asynchronously, and the first post-reset contention grants requester 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the two requester ports and the single memory port of the
//   two-way memory arbiter.
//
//   Per requester N (0/1):
//     reqN, rwN (1 = read), lockN, addrN, wdataN  -> arbiter
//     gntN, rvalidN, rdataN                       <- arbiter
//   Memory side:
//     mem_en, mem_rw, mem_addr, mem_wdata         <- arbiter
//     mem_rdata (valid one cycle after a read)    -> arbiter
//
//   modport slave  : the arbiter's view
//   modport master : the environment's view (requesters plus memory model)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int DATA_W = 64
);
    logic              req0;
    logic              rw0;
    logic              lock0;
    logic [DATA_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              rw1;
    logic              lock1;
    logic [DATA_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    logic              mem_en;
    logic              mem_rw;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, rw0, lock0, addr0, wdata0,
        input  req1, rw1, lock1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_en, mem_rw, mem_addr, mem_wdata
    );

    modport master (
        output req0, rw0, lock0, addr0, wdata0,
        output req1, rw1, lock1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_en, mem_rw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-requester arbiter in front of a single memory port. One access is
//   granted per cycle. Contention alternates between requesters unless the
//   current owner holds a lock, which is honoured for at most MAX_HOLD
//   consecutive grants while the other side waits. Reads return one cycle
//   after the grant; a registered tag routes the data to the right owner.
//
//   Ports:
//     clk   : single clock, rising edge
//     rst_n : asynchronous, active-low reset
//     bus   : mem_arbiter_if.slave (requester and memory signals)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DATA_W   = 64,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_arbiter_if.slave     bus
);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

    // State names the requester granted on the previous cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic              lock_reg, lock_next;       // owner's lock on its last grant
    logic              tag_valid_reg, tag_valid_next;
    logic              tag_id_reg, tag_id_next;   // owner of the read in flight

    logic              gnt0, gnt1;
    logic              keep_owner;
    logic [HOLD_W-1:0] hold_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            hold_cnt_reg  <= '0;
            lock_reg      <= 1'b0;
            tag_valid_reg <= 1'b0;
            tag_id_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_cnt_reg  <= hold_cnt_next;
            lock_reg      <= lock_next;
            tag_valid_reg <= tag_valid_next;
            tag_id_reg    <= tag_id_next;
        end
    end

    always_comb begin
        gnt0           = 1'b0;
        gnt1           = 1'b0;
        state_next     = IDLE;
        hold_cnt_next  = '0;
        lock_next      = 1'b0;
        tag_valid_next = 1'b0;
        tag_id_next    = 1'b0;

        // The lock only wins while the owner is below its hold budget.
        keep_owner = lock_reg && (hold_cnt_reg < HOLD_MAX);
        hold_inc   = (hold_cnt_reg == HOLD_MAX) ? HOLD_MAX : hold_cnt_reg + HOLD_W'(1);

        // Grants are gated by rst_n so they drop at once while reset is held.
        if (rst_n) begin
            if (bus.req0 && !bus.req1) begin
                gnt0 = 1'b1;
            end else if (bus.req1 && !bus.req0) begin
                gnt1 = 1'b1;
            end else if (bus.req0 && bus.req1) begin
                case (state_reg)
                    OWN0:    if (keep_owner) gnt0 = 1'b1; else gnt1 = 1'b1;
                    OWN1:    if (keep_owner) gnt1 = 1'b1; else gnt0 = 1'b1;
                    default: gnt0 = 1'b1;
                endcase
            end
        end

        if (gnt0) begin
            state_next     = OWN0;
            lock_next      = bus.lock0;
            tag_valid_next = bus.rw0;
            tag_id_next    = 1'b0;
            hold_cnt_next  = (state_reg == OWN0) ? hold_inc : '0;
        end else if (gnt1) begin
            state_next     = OWN1;
            lock_next      = bus.lock1;
            tag_valid_next = bus.rw1;
            tag_id_next    = 1'b1;
            hold_cnt_next  = (state_reg == OWN1) ? hold_inc : '0;
        end
    end

    // Memory port mux; idle value is a read strobe-less "read" with zero bus.
    always_comb begin
        bus.mem_en    = gnt0 | gnt1;
        bus.mem_rw    = 1'b1;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt0) begin
            bus.mem_rw    = bus.rw0;
            bus.mem_addr  = bus.addr0;
            bus.mem_wdata = bus.wdata0;
        end else if (gnt1) begin
            bus.mem_rw    = bus.rw1;
            bus.mem_addr  = bus.addr1;
            bus.mem_wdata = bus.wdata1;
        end
    end

    // Read return: memory data arrives the cycle after the grant, so it is
    // steered combinationally by the registered tag and zeroed otherwise.
    always_comb begin
        bus.gnt0    = gnt0;
        bus.gnt1    = gnt1;
        bus.rvalid0 = tag_valid_reg && !tag_id_reg;
        bus.rvalid1 = tag_valid_reg &&  tag_id_reg;
        bus.rdata0  = bus.rvalid0 ? bus.mem_rdata : '0;
        bus.rdata1  = bus.rvalid1 ? bus.mem_rdata : '0;
    end

endmodule
